// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer sequencer: FSM state encoding,
// default layer sizes and a small width helper.
package dense_pkg;

    localparam int IN_N  = 128;
    localparam int OUT_N = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_BIAS  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/dense_loop_cnt.sv
// Generic modulo-STOP loop counter with synchronous clear and a wrap flag
// that fires on the enabled cycle holding the last count.
module dense_loop_cnt #(
    parameter int STOP  = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             co
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(STOP - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign co  = en & (cnt_q == LAST);

endmodule

// File: rtl/dense_layer_ctrl.sv
// Sequencer for one dense layer: walks every output neuron, streams the
// input/weight reads into the MAC, drains, adds bias and writes the result.
module dense_layer_ctrl #(
    parameter int IN_N    = dense_pkg::IN_N,
    parameter int OUT_N   = dense_pkg::OUT_N,
    parameter int IN_W    = 7,
    parameter int OUT_W   = 4,
    parameter int WA_W    = 11,
    parameter int RD_LAT  = 1,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [IN_W-1:0]  in_addr,
    output logic [WA_W-1:0]  w_addr,
    output logic             mac_en,
    output logic             acc_clr,
    output logic             bias_en,
    output logic             out_we,
    output logic [OUT_W-1:0] out_addr
);

    import dense_pkg::*;

    localparam int DRAIN_N = RD_LAT + MAC_LAT;
    localparam int DR_W    = cnt_width(DRAIN_N);

    state_e state_q;
    state_e state_d;

    logic [WA_W-1:0]   w_addr_q;
    logic [WA_W-1:0]   w_addr_d;
    logic [RD_LAT-1:0] mac_pipe_q;
    logic [RD_LAT-1:0] mac_pipe_d;

    logic [IN_W-1:0]   in_cnt;
    logic [OUT_W-1:0]  out_cnt;
    logic [DR_W-1:0]   drain_cnt_unused;
    logic              in_co;
    logic              out_co;
    logic              dr_co;
    logic              launch;
    logic              rd_en_w;

    assign launch  = (state_q == ST_IDLE) && start;
    assign rd_en_w = (state_q == ST_MAC);

    dense_loop_cnt #(.STOP(IN_N), .WIDTH(IN_W)) u_in_cnt (
        .clk (clk),
        .rst (rst),
        .en  (rd_en_w),
        .clr (state_q == ST_CLR),
        .cnt (in_cnt),
        .co  (in_co)
    );

    // out_idx only moves on an accepted write, so a stalled WRITE freezes it.
    dense_loop_cnt #(.STOP(OUT_N), .WIDTH(OUT_W)) u_out_cnt (
        .clk (clk),
        .rst (rst),
        .en  ((state_q == ST_WRITE) && out_ready),
        .clr (launch),
        .cnt (out_cnt),
        .co  (out_co)
    );

    dense_loop_cnt #(.STOP(DRAIN_N), .WIDTH(DR_W)) u_drain_cnt (
        .clk (clk),
        .rst (rst),
        .en  (state_q == ST_DRAIN),
        .clr (state_q == ST_CLR),
        .cnt (drain_cnt_unused),
        .co  (dr_co)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_CLR;
            ST_CLR:   state_d = ST_MAC;
            ST_MAC:   if (in_co) state_d = ST_DRAIN;
            ST_DRAIN: if (dr_co) state_d = ST_BIAS;
            ST_BIAS:  state_d = ST_WRITE;
            ST_WRITE: if (out_ready) state_d = out_co ? ST_DONE : ST_CLR;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Weight address runs straight through the whole layer; no multiply needed.
    always_comb begin
        w_addr_d = w_addr_q;
        if (launch) begin
            w_addr_d = '0;
        end else if (rd_en_w) begin
            w_addr_d = w_addr_q + WA_W'(1);
        end
    end

    always_comb begin
        mac_pipe_d    = mac_pipe_q << 1;
        mac_pipe_d[0] = rd_en_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            w_addr_q   <= '0;
            mac_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            w_addr_q   <= w_addr_d;
            mac_pipe_q <= mac_pipe_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign rd_en    = rd_en_w;
    assign in_addr  = in_cnt;
    assign w_addr   = w_addr_q;
    assign mac_en   = mac_pipe_q[RD_LAT-1];
    assign acc_clr  = (state_q == ST_CLR);
    assign bias_en  = (state_q == ST_BIAS);
    assign out_we   = (state_q == ST_WRITE);
    assign out_addr = out_cnt;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Scoreboard bench for dense_layer_ctrl: a cycle-level layer plan fills
// expectation queues, a per-cycle monitor pops and compares DUT events.
module tb_dense_layer_ctrl;

    localparam int IN_N    = 4;
    localparam int OUT_N   = 3;
    localparam int IN_W    = 2;
    localparam int OUT_W   = 2;
    localparam int WA_W    = 4;
    localparam int RD_LAT  = 1;
    localparam int MAC_LAT = 2;
    localparam int DRN     = RD_LAT + MAC_LAT;
    localparam int NCYC    = 800;
    localparam int NEVER   = 1000000;

    typedef struct {
        int c;
        int a;
        int b;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [IN_W-1:0]  in_addr;
    logic [WA_W-1:0]  w_addr;
    logic             mac_en;
    logic             acc_clr;
    logic             bias_en;
    logic             out_we;
    logic [OUT_W-1:0] out_addr;

    dense_layer_ctrl #(
        .IN_N(IN_N), .OUT_N(OUT_N), .IN_W(IN_W), .OUT_W(OUT_W),
        .WA_W(WA_W), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .in_addr   (in_addr),
        .w_addr    (w_addr),
        .mac_en    (mac_en),
        .acc_clr   (acc_clr),
        .bias_en   (bias_en),
        .out_we    (out_we),
        .out_addr  (out_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    bit exp_busy [NCYC];
    bit exp_clr  [NCYC];
    bit exp_bias [NCYC];
    bit zero_chk [NCYC];
    bit start_pl [NCYC];
    bit rst_pl   [NCYC];
    int ready_pl [NCYC];

    ev_t rd_q[$];
    ev_t mac_q[$];
    ev_t wr_q[$];
    ev_t done_q[$];

    int end_c = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp, input int c);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, c, act, exp);
        end
    endtask

    // Expected behaviour of one layer launched by start in cycle k: one CLR
    // cycle, IN_N reads, DRN drain cycles, one bias cycle, then a write held
    // for st_n stall cycles. Events after cycle 'cut' are lost to a reset there.
    task automatic plan_layer(input int k, input int st0, input int st1, input int st2,
                              input int cut, output int done_c);
        int st [3];
        int t;
        int rc;
        int bc;
        int wt;
        int acc;
        st[0] = st0;
        st[1] = st1;
        st[2] = st2;
        start_pl[k] = 1'b1;
        t = k + 1;
        for (int n = 0; n < OUT_N; n++) begin
            if (t <= cut) exp_clr[t] = 1'b1;
            for (int i = 0; i < IN_N; i++) begin
                rc = t + 1 + i;
                if (rc <= cut) rd_q.push_back('{c: rc, a: i, b: n * IN_N + i});
                if (rc + RD_LAT <= cut) mac_q.push_back('{c: rc + RD_LAT, a: 0, b: 0});
            end
            bc = t + IN_N + DRN + 1;
            if (bc <= cut) exp_bias[bc] = 1'b1;
            wt  = bc + 1;
            acc = wt + st[n];
            for (int c = wt; c < acc; c++) ready_pl[c] = 0;
            ready_pl[acc] = 1;
            if (acc <= cut) wr_q.push_back('{c: wt, a: n, b: acc});
            t = acc + 1;
        end
        done_c = t;
        if (done_c <= cut) done_q.push_back('{c: done_c, a: 0, b: 0});
        for (int c = k + 1; c <= done_c && c <= cut; c++) exp_busy[c] = 1'b1;
        if (cut < done_c) begin
            rst_pl[cut]     = 1'b1;
            zero_chk[cut+1] = 1'b1;
        end
    endtask

    task automatic monitor(input int c);
        ev_t e;
        check("busy", 64'(busy), 64'(exp_busy[c]), c);
        check("acc_clr", 64'(acc_clr), 64'(exp_clr[c]), c);
        check("bias_en", 64'(bias_en), 64'(exp_bias[c]), c);
        if (zero_chk[c])
            check("reset_outputs",
                  64'({busy, done, rd_en, mac_en, acc_clr, bias_en, out_we, in_addr, out_addr, w_addr}),
                  64'd0, c);
        if (rd_en === 1'b1) begin
            if (rd_q.size() == 0) check("rd_unexpected", 64'(rd_en), 64'd0, c);
            else begin
                e = rd_q.pop_front();
                check("rd_cycle", 64'(c), 64'(e.c), c);
                check("in_addr", 64'(in_addr), 64'(e.a), c);
                check("w_addr", 64'(w_addr), 64'(e.b), c);
            end
        end
        if (mac_en === 1'b1) begin
            if (mac_q.size() == 0) check("mac_unexpected", 64'(mac_en), 64'd0, c);
            else begin
                e = mac_q.pop_front();
                check("mac_cycle", 64'(c), 64'(e.c), c);
            end
        end
        if (out_we === 1'b1) begin
            if (wr_q.size() == 0) check("we_unexpected", 64'(out_we), 64'd0, c);
            else begin
                e = wr_q[0];
                check("out_addr", 64'(out_addr), 64'(e.a), c);
                if (out_ready) begin
                    void'(wr_q.pop_front());
                    check("we_accept_cycle", 64'(c), 64'(e.b), c);
                end else begin
                    check("we_stall_window", 64'(c >= e.c && c < e.b), 64'd1, c);
                end
            end
        end
        if (done === 1'b1) begin
            if (done_q.size() == 0) check("done_unexpected", 64'(done), 64'd0, c);
            else begin
                e = done_q.pop_front();
                check("done_cycle", 64'(c), 64'(e.c), c);
            end
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge, in that order.
    always @(negedge clk) begin
        if (cyc < NCYC) begin
            rst       = rst_pl[cyc];
            start     = start_pl[cyc];
            out_ready = (ready_pl[cyc] >= 0) ? (ready_pl[cyc] != 0) : 1'($urandom_range(0, 1));
            if (cyc >= 1 && cyc <= end_c) monitor(cyc);
        end
    end

    initial begin
        int d;
        int k;
        int s0;
        int s1;
        int s2;
        for (int c = 0; c < NCYC; c++) ready_pl[c] = -1;
        for (int c = 0; c <= 2; c++) rst_pl[c] = 1'b1;
        for (int c = 1; c <= 4; c++) zero_chk[c] = 1'b1;

        plan_layer(5, 0, 0, 0, NEVER, d);          // plain layer, done at 36
        plan_layer(40, 0, 5, 0, NEVER, d);         // neuron-1 write stalled 5 cycles
        plan_layer(80, 0, 0, 0, NEVER, d);         // extra start pulse during MAC
        start_pl[83] = 1'b1;
        plan_layer(115, 0, 0, 0, 132, d);          // reset during neuron-1 DRAIN
        plan_layer(136, 0, 0, 0, NEVER, d);        // clean layer after reset
        for (int c = 170; c <= 202; c++) start_pl[c] = 1'b1;
        plan_layer(170, 0, 0, 0, NEVER, d);        // start held: back-to-back
        plan_layer(d + 1, 0, 0, 0, NEVER, d);

        for (int r = 0; r < 4; r++) begin
            k  = d + 1 + int'($urandom_range(1, 4));
            s0 = int'($urandom_range(0, 4));
            s1 = int'($urandom_range(0, 4));
            s2 = int'($urandom_range(0, 4));
            plan_layer(k, s0, s1, s2, NEVER, d);
            start_pl[int'($urandom_range(k + 1, d))] = 1'b1;
        end
        end_c = d + 6;

        wait (cyc >= end_c + 1);
        #1;
        check("rd_left", 64'(rd_q.size()), 64'd0, cyc);
        check("mac_left", 64'(mac_q.size()), 64'd0, cyc);
        check("wr_left", 64'(wr_q.size()), 64'd0, cyc);
        check("done_left", 64'(done_q.size()), 64'd0, cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
